elevator_scan_ctrl: RTL and testbench

Parametrised elevator controller that accepts floor requests at any time and serves them in SCAN order, keeping direction while requests remain ahead. It generalises the single-request elevator block: configurable floor count, per-floor travel time, door dwell timer, a pending-request bitmask and explicit direction and door outputs. It sits between the request decoder and the floor display/motor drive.

---
 rtl/elevator_scan_ctrl_if.sv | 34 +++
 rtl/elevator_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/elevator_scan_ctrl_if.sv
// Request/status bundle between the request decoder and elevator_scan_ctrl.
// emergencyStop exists only when ELEVATOR_ESTOP_EN is defined.
interface elevator_scan_ctrl_if #(
  parameter int FLOORS  = 16,
  parameter int FLOOR_W = 4
);
  logic               requestValid;
  logic [FLOOR_W-1:0] requestFloor;
  logic               requestError;
  logic [FLOOR_W-1:0] currentFloor;
  logic               moving;
  logic               directionUp;
  logic               doorOpen;
  logic [FLOORS-1:0]  pending;
`ifdef ELEVATOR_ESTOP_EN
  logic               emergencyStop;
`endif

  modport master (
`ifdef ELEVATOR_ESTOP_EN
    output emergencyStop,
`endif
    output requestValid, requestFloor,
    input  requestError, currentFloor, moving, directionUp, doorOpen, pending
  );

  modport slave (
`ifdef ELEVATOR_ESTOP_EN
    input  emergencyStop,
`endif
    input  requestValid, requestFloor,
    output requestError, currentFloor, moving, directionUp, doorOpen, pending
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator controller: pending-request mask, per-floor travel timer, door dwell timer.
// Define ELEVATOR_ESTOP_EN to add emergencyStop, which freezes counters and state while high.
module elevator_scan_ctrl #(
  parameter int FLOORS        = 16,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  elevator_scan_ctrl_if.slave bus
);
  localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DOOR_W   = $clog2(DOOR_CYCLES + 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LOAD   = DOOR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;

  state_e              state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic                dir_up_q, dir_up_d;
  logic [FLOORS-1:0]   pend_q, pend_d;
  logic [TRAVEL_W-1:0] travel_q, travel_d;
  logic [DOOR_W-1:0]   door_q, door_d;
  logic                req_valid_q, req_valid_d;
  logic [FLOOR_W-1:0]  req_floor_q, req_floor_d;
  logic                req_err_q, req_err_d;

  logic                estop;
  logic                door_hit;
  logic [FLOORS-1:0]   pend_next;
  logic [FLOOR_W-1:0]  step_floor;

`ifdef ELEVATOR_ESTOP_EN
  assign estop = bus.emergencyStop;
`else
  assign estop = 1'b0;
`endif

  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m = '0;
    for (int i = 0; i < FLOORS; i++) if (FLOOR_W'(i) == f) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] above(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m = '0;
    for (int i = 0; i < FLOORS; i++) if (FLOOR_W'(i) > f) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] below(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m = '0;
    for (int i = 0; i < FLOORS; i++) if (FLOOR_W'(i) < f) m[i] = 1'b1;
    return m;
  endfunction

  // A request at the car's own floor while parked just (re)opens the door instead of queueing.
  assign door_hit   = req_valid_q && !estop && (req_floor_q == floor_q) &&
                      (state_q == S_IDLE || state_q == S_DOOR);
  assign pend_next  = pend_q | ((req_valid_q && !door_hit) ? onehot(req_floor_q) : '0);
  assign step_floor = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      floor_q     <= '0;
      dir_up_q    <= 1'b1;
      pend_q      <= '0;
      travel_q    <= '0;
      door_q      <= '0;
      req_valid_q <= 1'b0;
      req_floor_q <= '0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_up_q    <= dir_up_d;
      pend_q      <= pend_d;
      travel_q    <= travel_d;
      door_q      <= door_d;
      req_valid_q <= req_valid_d;
      req_floor_q <= req_floor_d;
      req_err_q   <= req_err_d;
    end
  end

  // NOTE: every _d takes its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    dir_up_d    = dir_up_q;
    pend_d      = pend_next;
    travel_d    = travel_q;
    door_d      = door_q;
    req_valid_d = bus.requestValid && (int'(bus.requestFloor) < FLOORS);
    req_floor_d = bus.requestFloor;
    req_err_d   = bus.requestValid && (int'(bus.requestFloor) >= FLOORS);

    if (!estop) begin
      unique case (state_q)
        S_IDLE: begin
          if (door_hit) begin
            state_d = S_DOOR;
            door_d  = DOOR_LOAD;
          end else if (pend_next == '0) begin
            state_d = S_IDLE;
          end else if ((pend_next & onehot(floor_q)) != '0) begin
            pend_d  = pend_next & ~onehot(floor_q);
            state_d = S_DOOR;
            door_d  = DOOR_LOAD;
          end else begin
            state_d  = S_MOVE;
            travel_d = TRAVEL_LOAD;
            if (dir_up_q && (pend_next & above(floor_q)) != '0) dir_up_d = 1'b1;
            else if ((pend_next & below(floor_q)) != '0)        dir_up_d = 1'b0;
            else                                                dir_up_d = 1'b1;
          end
        end
        S_MOVE: begin
          if (travel_q != '0) begin
            travel_d = travel_q - TRAVEL_W'(1);
          end else begin
            floor_d = step_floor;
            if ((pend_next & onehot(step_floor)) != '0) begin
              pend_d  = pend_next & ~onehot(step_floor);
              state_d = S_DOOR;
              door_d  = DOOR_LOAD;
            end else if ((pend_next & (dir_up_q ? above(step_floor) : below(step_floor))) != '0) begin
              travel_d = TRAVEL_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DOOR: begin
          if (door_hit)            door_d  = DOOR_LOAD;
          else if (door_q == '0)   state_d = S_IDLE;
          else                     door_d  = door_q - DOOR_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.moving       = (state_q == S_MOVE);
    bus.doorOpen     = (state_q == S_DOOR);
    bus.currentFloor = floor_q;
    bus.directionUp  = dir_up_q;
    bus.pending      = pend_q;
    bus.requestError = req_err_q;
  end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl; timings are hand-derived edge offsets from each request.
// Define ELEVATOR_ESTOP_EN for both bench and RTL to exercise the emergency-stop scenario.
module tb_elevator_scan_ctrl;
  localparam int FLOORS        = 16;
  localparam int FLOOR_W       = 5;
  localparam int TRAVEL_CYCLES = 4;
  localparam int DOOR_CYCLES   = 6;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_n   = 0;
  int   t0;
  int   t1;

  elevator_scan_ctrl_if #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) bus();

  elevator_scan_ctrl #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W),
    .TRAVEL_CYCLES(TRAVEL_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic goto(input int target);
    while (edge_n < target) step(1);
  endtask

  // Presents one request for a single edge; returns 1 ns after that edge.
  task automatic send(input int f);
    bus.requestValid = 1'b1;
    bus.requestFloor = FLOOR_W'(f);
    step(1);
    bus.requestValid = 1'b0;
    bus.requestFloor = '0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.requestValid = 1'b0;
    bus.requestFloor = '0;
`ifdef ELEVATOR_ESTOP_EN
    bus.emergencyStop = 1'b0;
`endif
    #12;
    check("rst_floor",   int'(bus.currentFloor), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_dir",     int'(bus.directionUp), 1);
    check("rst_moving",  int'(bus.moving), 0);
    check("rst_door",    int'(bus.doorOpen), 0);
    check("rst_err",     int'(bus.requestError), 0);
    release_reset();

    // Single request, floor 3
    send(3); t0 = edge_n;
    check("t1_idle_e0",  int'(bus.moving), 0);
    goto(t0 + 1);  check("t1_move_e1", int'(bus.moving), 1);
                   check("t1_pend_e1", int'(bus.pending), 16'h0008);
    goto(t0 + 4);  check("t1_f0_e4",   int'(bus.currentFloor), 0);
    goto(t0 + 5);  check("t1_f1_e5",   int'(bus.currentFloor), 1);
    goto(t0 + 9);  check("t1_f2_e9",   int'(bus.currentFloor), 2);
    goto(t0 + 13); check("t1_f3_e13",  int'(bus.currentFloor), 3);
                   check("t1_door_e13", int'(bus.doorOpen), 1);
                   check("t1_pend_e13", int'(bus.pending), 0);
    goto(t0 + 18); check("t1_door_e18", int'(bus.doorOpen), 1);
    goto(t0 + 19); check("t1_door_e19", int'(bus.doorOpen), 0);
                   check("t1_stop_e19", int'(bus.moving), 0);

    // Reset mid-travel discards pending requests at once
    send(9);
    step(3);
    check("mr_moving", int'(bus.moving), 1);
    rst_n = 1'b0;
    #2;
    check("mr_pending", int'(bus.pending), 0);
    check("mr_moving0", int'(bus.moving), 0);
    check("mr_floor",   int'(bus.currentFloor), 0);
    release_reset();

    // Requests 5 then 2, one cycle apart: stop at 2 on the way up, then 5
    send(5); t0 = edge_n;
    send(2);
    goto(t0 + 8);  check("t2_f1_e8",   int'(bus.currentFloor), 1);
    goto(t0 + 9);  check("t2_f2_e9",   int'(bus.currentFloor), 2);
                   check("t2_door_e9", int'(bus.doorOpen), 1);
                   check("t2_pend_e9", int'(bus.pending), 16'h0020);
    goto(t0 + 14); check("t2_door_e14", int'(bus.doorOpen), 1);
    goto(t0 + 15); check("t2_door_e15", int'(bus.doorOpen), 0);
                   check("t2_idle_e15", int'(bus.moving), 0);
    goto(t0 + 16); check("t2_move_e16", int'(bus.moving), 1);
                   check("t2_dir_e16",  int'(bus.directionUp), 1);
    goto(t0 + 28); check("t2_f5_e28",   int'(bus.currentFloor), 5);
                   check("t2_door_e28", int'(bus.doorOpen), 1);
    goto(t0 + 34); check("t2_door_e34", int'(bus.doorOpen), 0);
                   check("t2_pend_e34", int'(bus.pending), 0);

    // Up to 8 with floor 1 requested mid-travel, then reverse
    goto(edge_n + 1);
    send(8); t0 = edge_n;
    goto(t0 + 5);  check("t3_f6", int'(bus.currentFloor), 6);
    send(1);
    goto(t0 + 13); check("t3_f8",    int'(bus.currentFloor), 8);
                   check("t3_door8", int'(bus.doorOpen), 1);
                   check("t3_pend8", int'(bus.pending), 16'h0002);
    goto(t0 + 19); check("t3_idle",  int'(bus.moving), 0);
                   check("t3_dirup", int'(bus.directionUp), 1);
    goto(t0 + 20); check("t3_move_dn", int'(bus.moving), 1);
                   check("t3_dir_dn",  int'(bus.directionUp), 0);
    goto(t0 + 24); check("t3_f7",    int'(bus.currentFloor), 7);
    goto(t0 + 48); check("t3_f1",    int'(bus.currentFloor), 1);
                   check("t3_door1", int'(bus.doorOpen), 1);
                   check("t3_dir1",  int'(bus.directionUp), 0);
    goto(t0 + 54); check("t3_close", int'(bus.doorOpen), 0);
                   check("t3_pend0", int'(bus.pending), 0);

    // Out-of-range requests, including the first invalid floor
    send(20); t0 = edge_n;
    check("t4_err20",    int'(bus.requestError), 1);
    goto(t0 + 1);
    check("t4_err_pulse", int'(bus.requestError), 0);
    check("t4_pend",      int'(bus.pending), 0);
    check("t4_moving",    int'(bus.moving), 0);
    send(16);
    check("t4_err16",    int'(bus.requestError), 1);
    goto(edge_n + 2);
    check("t4_pend16",   int'(bus.pending), 0);
    check("t4_floor",    int'(bus.currentFloor), 1);

    // Door at 6 re-requested at door counter 1 keeps it open a further 6 cycles
    send(6); t0 = edge_n;
    goto(t0 + 1);  check("t5_dir_up", int'(bus.directionUp), 1);
    goto(t0 + 21); check("t5_f6",     int'(bus.currentFloor), 6);
                   check("t5_door",   int'(bus.doorOpen), 1);
    goto(t0 + 25);
    send(6);
    goto(t0 + 27); check("t5_door_e27", int'(bus.doorOpen), 1);
    goto(t0 + 32); check("t5_door_e32", int'(bus.doorOpen), 1);
    goto(t0 + 33); check("t5_door_e33", int'(bus.doorOpen), 0);
                   check("t5_pend",     int'(bus.pending), 0);

    // Request for the parked car's floor opens the door without queueing
    goto(t0 + 34);
    send(6); t1 = edge_n;
    goto(t1 + 1); check("t5i_door_open", int'(bus.doorOpen), 1);
                  check("t5i_pend",      int'(bus.pending), 0);
    goto(t1 + 6); check("t5i_door_hold", int'(bus.doorOpen), 1);
    goto(t1 + 7); check("t5i_door_shut", int'(bus.doorOpen), 0);

`ifdef ELEVATOR_ESTOP_EN
    // Emergency stop for 10 edges mid-floor delays arrival by 10 cycles
    send(8); t0 = edge_n;
    goto(t0 + 2);
    bus.emergencyStop = 1'b1;
    goto(t0 + 12); check("es_frozen_floor", int'(bus.currentFloor), 6);
                   check("es_frozen_move",  int'(bus.moving), 1);
    bus.emergencyStop = 1'b0;
    goto(t0 + 14); check("es_not_yet", int'(bus.currentFloor), 6);
    goto(t0 + 15); check("es_arrive7", int'(bus.currentFloor), 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
